// File: rtl/fetch_pkg.sv
// fetch_pkg: RV32I opcodes and immediate-format classification shared by the fetch front end.
package fetch_pkg;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;
  function automatic imm_type_e imm_type(input logic [6:0] op);
    case (op)
      OP_IMM, LOAD, JALR: return IMM_I;
      STORE:              return IMM_S;
      BRANCH:             return IMM_B;
      LUI, AUIPC:         return IMM_U;
      JAL:                return IMM_J;
      default:            return IMM_NONE;
    endcase
  endfunction
endpackage

// File: rtl/fetch_unit_imm_decode.sv
// imm_decode: combinational RV32I immediate extraction, sign-extended to the address width.
module imm_decode import fetch_pkg::*; #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic [31:0]              instr_i,
  output logic [ADDRESS_WIDTH-1:0] imm_o
);
  imm_type_e t;
  logic [31:0] imm;
  always_comb begin
    t = imm_type(instr_i[6:0]);
    imm = t == IMM_I ? {{20{instr_i[31]}}, instr_i[31:20]} :
          t == IMM_S ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
          t == IMM_B ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
          t == IMM_U ? {instr_i[31:12], 12'b0} :
          t == IMM_J ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
          32'b0;
    imm_o = ADDRESS_WIDTH'($signed(imm));
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, one-cycle imem requester and FIFO_DEPTH fetch queue with redirect flush.
module fetch_unit import fetch_pkg::*; #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter int                       FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr_out,
  output logic [ADDRESS_WIDTH-1:0] pc_out,
  output logic [ADDRESS_WIDTH-1:0] imm_out,
  output logic [6:0]               opcode_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, req_pc_q;
  logic [PW:0] count_q, count_d, occ;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic inflight_q, inflight_d, push, pop, has_head;
  logic [1:0] unused_redirect_lo;
  logic [DATA_WIDTH-1:0] ins_mem_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem_q [FIFO_DEPTH];
  assign unused_redirect_lo = redirect_pc[1:0];
  assign has_head = count_q != '0;
  assign instr_valid = has_head & ~redirect_valid & ~rst;
  assign pop = instr_valid & instr_ready;
  // a redirect in the response cycle discards the word simply by not pushing it
  assign push = inflight_q & ~redirect_valid & ~rst;
  assign occ = count_q + (PW+1)'(inflight_q) - (PW+1)'(pop);
  assign imem_req = en & ~rst & ~redirect_valid & (occ < (PW+1)'(FIFO_DEPTH));
  assign imem_addr = pc_q;
  always_comb begin
    pc_d = redirect_valid ? {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00} :
           imem_req ? pc_q + ADDRESS_WIDTH'(4) : pc_q;
    count_d = redirect_valid ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
    wptr_d = redirect_valid ? '0 : wptr_q + PW'(push);
    rptr_d = redirect_valid ? '0 : rptr_q + PW'(pop);
    inflight_d = imem_req;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
      count_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      count_q <= count_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      inflight_q <= inflight_d;
    end
    req_pc_q <= pc_q;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem_q[wptr_q] <= imem_rdata;
      pc_mem_q[wptr_q] <= req_pc_q;
    end
  end
  assign instr_out = has_head ? ins_mem_q[rptr_q] : '0;
  assign pc_out = has_head ? pc_mem_q[rptr_q] : '0;
  assign opcode_out = instr_out[6:0];
  imm_decode #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_imm (.instr_i(instr_out[31:0]), .imm_o(imm_out));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch stimulus checked each cycle against a queue-level reference model.
module tb_fetch_unit;
  localparam int D = 4;
  logic clk = 0;
  logic rst, en, imem_req, redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr_out, pc_out, imm_out;
  logic [6:0] opcode_out;
  always #5 clk = ~clk;

  fetch_unit #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .pc_out(pc_out), .imm_out(imm_out), .opcode_out(opcode_out)
  );

  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t mq[$];
  logic [31:0] m_pc, m_inf_pc, seen_addr;
  bit m_inf, seen_req;
  int compared = 0, mismatched = 0;
  logic [31:0] imms [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h1234_5000, 32'h0, 32'h0};

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0] op;
    case (a)
      32'h200: return 32'hFFF0_0093;
      32'h204: return 32'hFE00_0EE3;
      32'h208: return 32'h1234_52B7;
      32'h20C: return 32'h0000_006F;
      32'h210: return 32'h0000_0033;
      default: ;
    endcase
    if (a < 32'h1000) return a ^ 32'hA5A5_0000;
    h = a * 32'h9E37_79B1;
    case (h[10:8])
      3'd0: op = 7'h13;
      3'd1: op = 7'h03;
      3'd2: op = 7'h67;
      3'd3: op = 7'h23;
      3'd4: op = 7'h63;
      3'd5: op = 7'h37;
      3'd6: op = h[11] ? 7'h17 : 7'h6F;
      default: op = 7'h33;
    endcase
    return {h[31:7], op};
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return 32'($signed(i[31:20]));
      7'h23: return 32'($signed({i[31:25], i[11:7]}));
      7'h63: return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      7'h37, 7'h17: return i & 32'hFFFF_F000;
      7'h6F: return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic sample();
    bit ev, pop, er;
    ent_t e;
    @(negedge clk);
    ev = !rst && !redirect_valid && mq.size() > 0;
    pop = ev && instr_ready;
    er = en && !rst && !redirect_valid && (mq.size() + int'(m_inf) - int'(pop) < D);
    chk("imem_req", imem_req, er);
    if (er) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, ev);
    if (!rst && mq.size() > 0) begin
      chk("instr_out", instr_out, mq[0].ins);
      chk("pc_out", pc_out, mq[0].pc);
      chk("imm_out", imm_out, ref_imm(mq[0].ins));
      chk("opcode_out", opcode_out, mq[0].ins & 32'h7F);
    end
    if (rst) begin
      m_pc = 32'h0; mq.delete(); m_inf = 0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc & ~32'h3; mq.delete(); m_inf = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_inf) begin
        e.pc = m_inf_pc; e.ins = memf(m_inf_pc); mq.push_back(e);
      end
      m_inf = er;
      if (er) begin
        m_inf_pc = m_pc; m_pc = m_pc + 32'd4;
      end
    end
    seen_req = imem_req;
    seen_addr = imem_addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    imem_rdata = seen_req ? memf(seen_addr) : $urandom;
  endtask

  task automatic run(input int n);
    repeat (n) begin sample(); tick(); end
  endtask

  initial begin
    rst = 1; en = 1; instr_ready = 1; redirect_valid = 0; redirect_pc = 0; imem_rdata = 0;
    m_pc = 0; m_inf = 0; m_inf_pc = 0; seen_req = 0; seen_addr = 0;
    tick();
    sample();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_imm", imm_out, 0);
    chk("rst_opcode", opcode_out, 0);
    tick();
    rst = 0;
    sample(); chk("first_req", imem_req, 1); chk("first_addr", imem_addr, 0); tick();
    sample(); chk("second_addr", imem_addr, 4); tick();
    sample(); chk("first_valid", instr_valid, 1); chk("first_pc", pc_out, 0);
    chk("first_instr", instr_out, 32'hA5A5_0000); tick();
    run(7);
    instr_ready = 0;
    run(8);
    sample(); chk("stall_req", imem_req, 0); tick();
    instr_ready = 1;
    run(6);
    redirect_valid = 1; redirect_pc = 32'h103;
    sample(); chk("redir_valid", instr_valid, 0); tick();
    redirect_valid = 0;
    sample(); chk("redir_req", imem_req, 1); chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid1", instr_valid, 0); tick();
    sample(); chk("redir_valid2", instr_valid, 0); tick();
    sample(); chk("redir_valid3", instr_valid, 1); chk("redir_pc", pc_out, 32'h100); tick();
    run(3);
    redirect_valid = 1; redirect_pc = 32'h200;
    sample(); tick();
    redirect_valid = 0;
    run(2);
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("imm_pc", pc_out, 32'h200 + 32'(4 * i));
      chk("imm_lit", imm_out, imms[i]);
      tick();
    end
    en = 0;
    run(3);
    en = 1;
    run(10);
    rst = 1; redirect_valid = 1; redirect_pc = 32'h300;
    sample(); chk("rr_req", imem_req, 0); tick();
    rst = 0; redirect_valid = 0;
    sample(); chk("rr_req1", imem_req, 1); chk("rr_addr", imem_addr, 0);
    chk("rr_valid1", instr_valid, 0); tick();
    sample(); chk("rr_valid2", instr_valid, 0); tick();
    sample(); chk("rr_valid3", instr_valid, 1); chk("rr_pc", pc_out, 0); tick();
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 99) == 0;
      en = $urandom_range(0, 9) < 8;
      instr_ready = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 29) == 0;
      redirect_pc = $urandom;
      run(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
